// File: rtl/gpa_fhdo_seq_pkg.sv
// Shared types and defaults for the gpa_fhdo_iface playback sequencer.
package gpa_fhdo_seq_pkg;
  localparam int DEF_ADDR_W       = 13;
  localparam int DEF_CH_W         = 24;
  localparam int DEF_INTERVAL_W   = 16;
  localparam int DEF_MIN_INTERVAL = 64;
  localparam int DEF_HOST_GUARD   = 40;

  localparam int NUM_CH = 4;
  localparam int CH_X   = 0;
  localparam int CH_Y   = 1;
  localparam int CH_Z   = 2;
  localparam int CH_Z2  = 3;

  // cycles after a strobe before another may follow (busy_i can lag valid_o by one)
  localparam int GUARD_CYC = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPT,
    S_WAIT,
    S_ISSUE,
    S_HOST
  } state_t;
endpackage

// File: rtl/gpa_fhdo_seq_timer.sv
// Sample-interval timer: loads clamp(interval)-1, counts down and saturates at 0.
module gpa_fhdo_seq_timer #(
  parameter int W   = 16,
  parameter int MIN = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_ival;

  assign w_ival = (i_val < W'(MIN)) ? W'(MIN) : i_val;

  always_ff @(posedge clk) begin
    if (rst || i_clr)       r_cnt <= '0;
    else if (i_load)        r_cnt <= w_ival - W'(1);
    else if (r_cnt != '0)   r_cnt <= r_cnt - W'(1);
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/gpa_fhdo_seq.sv
// Playback sequencer: BRAM -> hold regs -> timed 1-cycle strobe to gpa_fhdo_iface.
// Define GPA_FHDO_SEQ_HOST_WR_EN to build the host single-shot write port.
module gpa_fhdo_seq
  import gpa_fhdo_seq_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int CH_W         = DEF_CH_W,
  parameter int INTERVAL_W   = DEF_INTERVAL_W,
  parameter int MIN_INTERVAL = DEF_MIN_INTERVAL,
  parameter int HOST_GUARD   = DEF_HOST_GUARD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [INTERVAL_W-1:0]  interval_i,
  input  logic [ADDR_W-1:0]      start_addr_i,
  input  logic [ADDR_W-1:0]      end_addr_i,
  output logic                   mem_en_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  input  logic [NUM_CH*CH_W-1:0] mem_data_i,
  output logic [CH_W-1:0]        datax_o,
  output logic [CH_W-1:0]        datay_o,
  output logic [CH_W-1:0]        dataz_o,
  output logic [CH_W-1:0]        dataz2_o,
  output logic                   valid_o,
  input  logic                   busy_i,
  output logic                   running_o,
  output logic                   done_o,
`ifdef GPA_FHDO_SEQ_HOST_WR_EN
  input  logic                   host_req_i,
  input  logic [NUM_CH*CH_W-1:0] host_data_i,
  output logic                   host_ack_o,
`endif
  output logic                   late_o
);
  state_t                   r_state, w_nxt;
  logic [ADDR_W-1:0]        r_addr, r_end;
  logic [INTERVAL_W-1:0]    r_int;
  logic [NUM_CH*CH_W-1:0]   r_hold, r_data, w_out;
  logic                     r_late, r_done;
  logic [1:0]               r_guard;
  logic [INTERVAL_W-1:0]    w_cnt;
  logic                     w_zero, w_go, w_start;

  gpa_fhdo_seq_timer #(.W(INTERVAL_W), .MIN(MIN_INTERVAL)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start),
    .i_load (r_state == S_ISSUE),
    .i_val  (r_int),
    .o_cnt  (w_cnt),
    .o_zero (w_zero)
  );

  // Release WAIT when the timer hits 0 in the ISSUE cycle itself, so strobes
  // land exactly one programmed interval apart.
  assign w_go    = (r_state == S_WAIT) && (w_cnt <= INTERVAL_W'(1)) && !busy_i && (r_guard == '0);
  assign w_start = (r_state == S_IDLE) && (w_nxt == S_FETCH);

`ifdef GPA_FHDO_SEQ_HOST_WR_EN
  state_t r_ret;
  logic   w_host_idle, w_host_wait;
  assign w_host_idle = host_req_i && (r_guard == '0);
  assign w_host_wait = host_req_i && (r_guard == '0) && !busy_i &&
                       (w_cnt > INTERVAL_W'(HOST_GUARD));
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_nxt = S_FETCH;
`ifdef GPA_FHDO_SEQ_HOST_WR_EN
        else if (w_host_idle) w_nxt = S_HOST;
`endif
      end
      S_FETCH: w_nxt = S_CAPT;
      S_CAPT:  w_nxt = S_WAIT;
      S_WAIT: begin
        if (w_go) w_nxt = S_ISSUE;
`ifdef GPA_FHDO_SEQ_HOST_WR_EN
        else if (w_host_wait) w_nxt = S_HOST;
`endif
      end
      S_ISSUE: w_nxt = (r_addr == r_end) ? S_IDLE : S_FETCH;
`ifdef GPA_FHDO_SEQ_HOST_WR_EN
      S_HOST:  w_nxt = r_ret;
`endif
      default: w_nxt = S_IDLE;
    endcase
    if (stop_i) w_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_end   <= '0;
      r_int   <= '0;
      r_hold  <= '0;
      r_data  <= '0;
      r_late  <= 1'b0;
      r_done  <= 1'b0;
      r_guard <= '0;
    end else begin
      r_state <= w_nxt;
      r_done  <= (r_state == S_ISSUE) && (r_addr == r_end) && !stop_i;
      if (r_guard != '0) r_guard <= r_guard - 2'd1;
      if (w_start) begin
        r_addr <= start_addr_i;
        r_end  <= end_addr_i;
        r_int  <= interval_i;
        r_late <= 1'b0;
      end
      if (r_state == S_CAPT) r_hold <= mem_data_i;
      if ((r_state == S_WAIT) && w_zero && busy_i) r_late <= 1'b1;
      if (w_nxt == S_ISSUE) r_data <= r_hold;
      if (r_state == S_ISSUE) begin
        r_addr  <= r_addr + ADDR_W'(1);
        r_guard <= 2'(GUARD_CYC);
      end
`ifdef GPA_FHDO_SEQ_HOST_WR_EN
      if (r_state == S_HOST) begin
        r_data  <= host_data_i;
        r_guard <= 2'(GUARD_CYC);
      end
`endif
    end
  end

`ifdef GPA_FHDO_SEQ_HOST_WR_EN
  always_ff @(posedge clk) begin
    if (rst)                  r_ret <= S_IDLE;
    else if (w_nxt == S_HOST) r_ret <= r_state;
  end
  assign host_ack_o = (r_state == S_HOST);
  assign w_out      = (r_state == S_HOST) ? host_data_i : r_data;
  assign valid_o    = (r_state == S_ISSUE) || (r_state == S_HOST);
`else
  assign w_out      = r_data;
  assign valid_o    = (r_state == S_ISSUE);
`endif

  assign mem_en_o   = (r_state == S_FETCH);
  assign mem_addr_o = (r_state == S_FETCH) ? r_addr : '0;
  assign datax_o    = w_out[CH_X*CH_W +: CH_W];
  assign datay_o    = w_out[CH_Y*CH_W +: CH_W];
  assign dataz_o    = w_out[CH_Z*CH_W +: CH_W];
  assign dataz2_o   = w_out[CH_Z2*CH_W +: CH_W];
  assign running_o  = (r_state != S_IDLE);
  assign done_o     = r_done;
  assign late_o     = r_late;
endmodule

// File: tb/tb_gpa_fhdo_seq.sv
// Directed bench for gpa_fhdo_seq: BRAM pattern model, busy responder, strobe monitor.
module tb_gpa_fhdo_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, stop_i = 1'b0, busy_i;
  logic [15:0] interval_i = '0;
  logic [12:0] start_addr_i = '0, end_addr_i = '0;
  logic        mem_en_o;
  logic [12:0] mem_addr_o;
  logic [95:0] mem_q = '0;
  logic [23:0] datax_o, datay_o, dataz_o, dataz2_o;
  logic        valid_o, running_o, done_o, late_o;
  logic        w_hack;
`ifdef GPA_FHDO_SEQ_HOST_WR_EN
  logic        hreq = 1'b0;
  logic [95:0] hdata = '0;
`endif

  int n_run = 0, n_fail = 0, cyc = 0, done_cnt = 0, blen = 0, bcnt = 0;
  int q_cyc[$];
  logic [95:0] q_dat[$];

  gpa_fhdo_seq dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
    .interval_i(interval_i), .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_q),
    .datax_o(datax_o), .datay_o(datay_o), .dataz_o(dataz_o), .dataz2_o(dataz2_o),
    .valid_o(valid_o), .busy_i(busy_i), .running_o(running_o), .done_o(done_o),
`ifdef GPA_FHDO_SEQ_HOST_WR_EN
    .host_req_i(hreq), .host_data_i(hdata), .host_ack_o(w_hack),
`endif
    .late_o(late_o)
  );
`ifndef GPA_FHDO_SEQ_HOST_WR_EN
  assign w_hack = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [95:0] pat(input logic [12:0] a);
    logic [23:0] x;
    x = {11'd0, a};
    return {x | 24'hC00000, x | 24'h800000, x | 24'h400000, x};
  endfunction

  // BRAM: one-cycle read latency
  always @(posedge clk) if (mem_en_o) mem_q <= pat(mem_addr_o);

  // serialiser: busy for blen cycles after each strobe it sees
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid_o && blen > 0) bcnt <= blen;
    else if (bcnt > 0)       bcnt <= bcnt - 1;
  end
  assign busy_i = (bcnt != 0);

  always @(negedge clk) begin
    if (valid_o && !w_hack) begin
      q_cyc.push_back(cyc);
      q_dat.push_back({dataz2_o, dataz_o, datay_o, datax_o});
    end
    if (done_o) done_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic go(input int ival, input logic [12:0] sa, input logic [12:0] ea);
    @(negedge clk);
    q_cyc.delete(); q_dat.delete(); done_cnt = 0;
    interval_i = 16'(ival); start_addr_i = sa; end_addr_i = ea; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
    chk(tag, 128'(done_cnt != 0), 128'd1);
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_issues(input string tag, input int cnt, input int budget);
    int n = 0;
    while (q_cyc.size() < cnt && n < budget) begin @(negedge clk); n++; end
    chk(tag, 128'(q_cyc.size() >= cnt), 128'd1);
  endtask

  task automatic chk_seq(input string tag, input logic [12:0] a0, input int n, input int gap);
    logic [12:0] a;
    a = a0;
    chk({tag, " count"}, 128'(q_cyc.size()), 128'(n));
    for (int i = 0; i < n && i < q_cyc.size(); i++) begin
      chk($sformatf("%s data%0d", tag, i), 128'(q_dat[i]), 128'(pat(a)));
      if (i > 0 && gap > 0) chk($sformatf("%s gap%0d", tag, i), 128'(q_cyc[i] - q_cyc[i-1]), 128'(gap));
      a = a + 13'd1;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst running", 128'(running_o), 128'd0);
    chk("rst valid",   128'(valid_o),   128'd0);
    chk("rst done",    128'(done_o),    128'd0);
    chk("rst late",    128'(late_o),    128'd0);
    chk("rst mem_en",  128'(mem_en_o),  128'd0);
    chk("rst datax",   128'(datax_o),   128'd0);
    rst = 1'b0;

    // nominal: spacing set by timer, busy shorter than interval
    blen = 50;
    go(100, 13'h0000, 13'h0003);
    wait_done("t1 done", 1000);
    chk_seq("t1", 13'h0000, 4, 100);
    chk("t1 done once", 128'(done_cnt), 128'd1);
    chk("t1 late", 128'(late_o), 128'd0);
    chk("t1 idle", 128'(running_o), 128'd0);
    chk("t1 hold x", 128'(datax_o), 128'h3);

    // clamped interval, busy dominates: 80 busy + 2 guard cycles
    blen = 80;
    go(10, 13'h0005, 13'h0007);
    wait_done("t2 done", 1000);
    chk_seq("t2", 13'h0005, 3, 82);
    chk("t2 late", 128'(late_o), 128'd1);

    // address wrap
    blen = 0;
    go(64, 13'h1FFE, 13'h0001);
    wait_done("t3 done", 1000);
    chk_seq("t3", 13'h1FFE, 4, 0);
    chk("t3 done once", 128'(done_cnt), 128'd1);

    // stop in WAIT of third sample; start while running ignored
    go(100, 13'h0010, 13'h0020);
    wait_issues("t4 first", 1, 200);
    repeat (5) @(negedge clk);
    start_addr_i = 13'h0055; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_issues("t4 second", 2, 300);
    repeat (20) @(negedge clk);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("t4 stop idle", 128'(running_o), 128'd0);
    repeat (150) @(negedge clk);
    chk_seq("t4", 13'h0010, 2, 100);
    chk("t4 no done", 128'(done_cnt), 128'd0);
    go(64, 13'h0010, 13'h0010);
    wait_done("t4 restart done", 500);
    chk_seq("t4r", 13'h0010, 1, 0);

    // reset while in CAPT
    go(64, 13'h0030, 13'h0031);
    chk("t5 fetch en", 128'(mem_en_o), 128'd1);
    chk("t5 fetch addr", 128'(mem_addr_o), 128'h30);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5 running", 128'(running_o), 128'd0);
    chk("t5 mem_en",  128'(mem_en_o),  128'd0);
    chk("t5 datax",   128'(datax_o),   128'd0);
    chk("t5 valid",   128'(valid_o),   128'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5 no done", 128'(done_cnt), 128'd0);

`ifdef GPA_FHDO_SEQ_HOST_WR_EN
    // host write from IDLE: ack and strobe in the same cycle
    hdata = 96'h111111_222222_333333_444444;
    hreq = 1'b1;
    @(negedge clk);
    chk("h ack", 128'(w_hack), 128'd1);
    chk("h valid", 128'(valid_o), 128'd1);
    chk("h datax", 128'(datax_o), 128'h444444);
    hreq = 1'b0;
    // host request with little timer left waits past the next sample
    go(200, 13'h0040, 13'h0041);
    wait_issues("h first", 1, 100);
    repeat (170) @(negedge clk);
    hreq = 1'b1;
    begin
      int n = 0;
      while (!w_hack && n < 400) begin @(negedge clk); n++; end
    end
    chk("h defer ack", 128'(w_hack), 128'd1);
    chk("h defer after issue", 128'(q_cyc.size()), 128'd2);
    hreq = 1'b0;
    repeat (5) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
